// File: rtl/pattern_detector_cfg_if.sv
// Serial stream, configuration and result signals of the configurable pattern detector.
// master drives the stream/config side, slave is the detector.
interface pattern_detector_cfg_if #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8
);
    localparam int LW = $clog2(PAT_W + 1);

    logic             stream_in;
    logic             in_valid;
    logic             ovl_en;
    logic             cfg_load;
    logic [PAT_W-1:0] cfg_pattern;
    logic [LW-1:0]    cfg_len;
    logic             cnt_clr;
    logic             pattern_found;
    logic [CNT_W-1:0] match_count;

    modport master (
        output stream_in, in_valid, ovl_en, cfg_load, cfg_pattern, cfg_len, cnt_clr,
        input  pattern_found, match_count
    );

    modport slave (
        input  stream_in, in_valid, ovl_en, cfg_load, cfg_pattern, cfg_len, cnt_clr,
        output pattern_found, match_count
    );
endinterface

// File: rtl/pattern_detector_cfg.sv
// Runtime-configurable serial pattern detector: programmable 1..PAT_W bit pattern,
// overlapping/non-overlapping matching, Mealy match flag and saturating match counter.
module pattern_detector_cfg #(
    parameter int               PAT_W    = 8,
    parameter int               CNT_W    = 8,
    parameter logic [PAT_W-1:0] PAT_INIT = PAT_W'(5'b1_1010),
    parameter int               LEN_INIT = 5
) (
    input logic                   clk,
    input logic                   rst,
    pattern_detector_cfg_if.slave bus
);
    localparam int               LW       = $clog2(PAT_W + 1);
    localparam logic [LW-1:0]    FILL_MAX = LW'(PAT_W - 1);
    localparam logic [LW-1:0]    LEN_RST  = (LEN_INIT < 1 || LEN_INIT > PAT_W) ?
                                            LW'(PAT_W) : LW'(LEN_INIT);

    logic [PAT_W-1:0] pat_r;
    logic [LW-1:0]    len_r;
    logic [PAT_W-2:0] hist_r;
    logic [LW-1:0]    fill_r;
    logic [CNT_W-1:0] cnt_r;

    logic [PAT_W-1:0] window;
    logic [PAT_W-1:0] mask;
    logic [LW-1:0]    new_len;
    logic             accept;
    logic             fill_ok;
    logic             match;

    assign window = {hist_r, bus.stream_in};

    // only the low len_r window bits take part in the compare
    always_comb begin
        mask = '0;
        for (int i = 0; i < PAT_W; i++)
            mask[i] = (i < int'(len_r));
    end

    assign accept  = bus.in_valid && !bus.cfg_load;
    assign fill_ok = ({1'b0, fill_r} + (LW+1)'(1)) >= {1'b0, len_r};
    assign match   = rst && accept && fill_ok && (((window ^ pat_r) & mask) == '0);
    assign new_len = (bus.cfg_len == '0 || int'(bus.cfg_len) > PAT_W) ? LW'(PAT_W) : bus.cfg_len;

    always_ff @(posedge clk) begin
        if (!rst) begin
            pat_r  <= PAT_INIT;
            len_r  <= LEN_RST;
            hist_r <= '0;
            fill_r <= '0;
            cnt_r  <= '0;
        end else begin
            if (bus.cfg_load) begin
                // the stream bit presented alongside a load is dropped
                pat_r  <= bus.cfg_pattern;
                len_r  <= new_len;
                hist_r <= '0;
                fill_r <= '0;
            end else if (bus.in_valid) begin
                hist_r <= window[PAT_W-2:0];
                if (match && !bus.ovl_en)
                    fill_r <= '0;
                else if (fill_r != FILL_MAX)
                    fill_r <= fill_r + LW'(1);
            end

            if (bus.cnt_clr)
                cnt_r <= match ? CNT_W'(1) : '0;
            else if (match && cnt_r != '1)
                cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    assign bus.pattern_found = match;
    assign bus.match_count   = cnt_r;
endmodule

// File: tb/tb_pattern_detector_cfg.sv
// Directed test-plan sequences followed by random traffic, all checked against a
// queue-based reference model of the detector.
module tb_pattern_detector_cfg;
    localparam int PAT_W = 8;
    localparam int CNT_W = 8;
    localparam int LW    = $clog2(PAT_W + 1);
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pattern_detector_cfg_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();

    pattern_detector_cfg #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_vec = 0;
    int n_chk = 0;
    int n_err = 0;

    // reference model: accepted bits since restart, oldest first
    bit               m_q[$];
    logic [PAT_W-1:0] m_pat;
    int               m_len;
    int               m_cnt;

    function automatic int clamp(input int l);
        return (l == 0 || l > PAT_W) ? PAT_W : l;
    endfunction

    function automatic bit model_found(input bit s, input bit v, input bit ld, input bit rn);
        bit t[$];
        if (!rn || !v || ld) return 1'b0;
        t = m_q;
        t.push_back(s);
        if (t.size() < m_len) return 1'b0;
        for (int k = 0; k < m_len; k++)
            if (t[t.size()-1-k] != m_pat[k]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_pat = PAT_W'(5'b1_1010);
        m_len = 5;
        m_cnt = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one clock: drive at negedge, check flag before posedge, check count after
    task automatic apply(input bit s, input bit v, input bit ovl, input bit ld,
                         input logic [PAT_W-1:0] pat, input logic [LW-1:0] len,
                         input bit clr, input bit rn, output bit f);
        bit ef;
        @(negedge clk);
        bus.stream_in   = s;
        bus.in_valid    = v;
        bus.ovl_en      = ovl;
        bus.cfg_load    = ld;
        bus.cfg_pattern = pat;
        bus.cfg_len     = len;
        bus.cnt_clr     = clr;
        rst             = rn;
        n_vec++;
        #1;
        ef = model_found(s, v, ld, rn);
        f  = bus.pattern_found;
        chk("pattern_found", 32'(f), 32'(ef));
        @(posedge clk);
        if (!rn) model_reset();
        else begin
            if (ld) begin
                m_pat = pat;
                m_len = clamp(int'(len));
                m_q.delete();
            end else if (v) begin
                m_q.push_back(s);
                if (ef && !ovl) m_q.delete();
                while (m_q.size() > PAT_W - 1) void'(m_q.pop_front());
            end
            if (clr) m_cnt = ef ? 1 : 0;
            else if (ef && m_cnt < CMAX) m_cnt++;
        end
        #1;
        chk("match_count", 32'(bus.match_count), 32'(m_cnt));
    endtask

    task automatic send(input logic [15:0] bits, input int n, input bit ovl, output logic [15:0] fm);
        bit f;
        fm = '0;
        for (int i = n - 1; i >= 0; i--) begin
            apply(bits[i], 1'b1, ovl, 1'b0, '0, '0, 1'b0, 1'b1, f);
            fm = {fm[14:0], f};
        end
    endtask

    task automatic load(input logic [PAT_W-1:0] pat, input logic [LW-1:0] len, input bit clr);
        bit f;
        apply(1'b0, 1'b0, 1'b1, 1'b1, pat, len, clr, 1'b1, f);
    endtask

    initial begin
        logic [15:0] fm;
        bit f;
        bus.stream_in = 0; bus.in_valid = 0; bus.ovl_en = 0; bus.cfg_load = 0;
        bus.cfg_pattern = '0; bus.cfg_len = '0; bus.cnt_clr = 0;
        model_reset();

        // reset with valid ones offered: flag stays low, counter zero
        apply(1'b1, 1'b1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, f);
        apply(1'b1, 1'b1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, f);
        chk("reset_cnt", 32'(bus.match_count), 32'd0);

        // default pattern, overlapping
        send(16'b11010_11010, 10, 1'b1, fm);
        chk("dflt_hits", 32'(fm[9:0]), 32'b0000100001);
        chk("dflt_cnt", 32'(bus.match_count), 32'd2);

        // 101 overlapping then non-overlapping
        load(8'b101, 4'd3, 1'b0);
        send(16'b10101, 5, 1'b1, fm);
        chk("ovl_hits", 32'(fm[4:0]), 32'b00101);
        load(8'b101, 4'd3, 1'b0);
        send(16'b10101, 5, 1'b0, fm);
        chk("novl_hits", 32'(fm[4:0]), 32'b00100);

        // gap with in_valid low keeps the partial match
        load(8'b11010, 4'd5, 1'b1);
        send(16'b110, 3, 1'b1, fm);
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b1, f);
            chk("gap_flag", 32'(f), 32'd0);
        end
        send(16'b10, 2, 1'b1, fm);
        chk("gap_hits", 32'(fm[1:0]), 32'b01);

        // reset mid-pattern discards the partial match
        send(16'b1101, 4, 1'b1, fm);
        apply(1'b0, 1'b1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, f);
        chk("rst_mid_cnt", 32'(bus.match_count), 32'd0);
        send(16'b0, 1, 1'b1, fm);
        chk("rst_mid_hit", 32'(fm[0]), 32'd0);

        // length 1 counter saturation, then clear together with a match
        load(8'b1, 4'd1, 1'b1);
        send(16'b111, 3, 1'b0, fm);
        chk("len1_cnt3", 32'(bus.match_count), 32'd3);
        for (int i = 0; i < CMAX + 4; i++) send(16'b1, 1, 1'b0, fm);
        chk("sat_cnt", 32'(bus.match_count), 32'(CMAX));
        apply(1'b1, 1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, f);
        chk("clr_match", 32'(bus.match_count), 32'd1);

        // cfg_len 0 clamps to full width; match only on the PAT_W-th bit
        load(8'hA5, 4'd0, 1'b0);
        send(16'b10100101, 8, 1'b1, fm);
        chk("len0_hits", 32'(fm[7:0]), 32'b00000001);
        // load while a valid bit is offered: bit ignored, flag low
        apply(1'b1, 1'b1, 1'b1, 1'b1, 8'b1, 4'd1, 1'b0, 1'b1, f);
        chk("ld_valid_flag", 32'(f), 32'd0);
        send(16'b1, 1, 1'b1, fm);
        chk("ld_new_cfg", 32'(fm[0]), 32'd1);

        // random traffic, short patterns favoured so matches occur
        for (int i = 0; i < 1500; i++) begin
            bit ld, rn;
            logic [LW-1:0] ln;
            ld = ($urandom_range(99) < 3);
            rn = ($urandom_range(199) != 0);
            ln = LW'($urandom_range(9) < 7 ? $urandom_range(4) : $urandom_range(15));
            apply(1'($urandom), ($urandom_range(3) != 0), 1'($urandom), ld,
                  PAT_W'($urandom), ln, ($urandom_range(99) < 3), rn, f);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
